// File: rtl/servgrid_wb_host.sv
// rtl/servgrid_wb_host.sv - single-beat Wishbone initiator for the servgrid processor port
// Takes one command at a time, runs one classic transfer with a bus timeout, and holds the response until consumed.
module servgrid_wb_host #(
    parameter int          aw       = 32,
    parameter int          timeout  = 255,
    parameter logic [31:0] err_data = 32'hDEADBEEF
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [aw-1:0] cmd_adr,
    input  logic [31:0]   cmd_dat,
    input  logic [3:0]    cmd_sel,
    input  logic          cmd_we,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [aw-1:0] o_wb_proc_adr,
    output logic [31:0]   o_wb_proc_dat,
    output logic [3:0]    o_wb_proc_sel,
    output logic          o_wb_proc_we,
    output logic          o_wb_proc_stb,
    input  logic [31:0]   i_wb_proc_rdt,
    input  logic          i_wb_proc_ack
);

    localparam int cw = $clog2(timeout + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t          state_q, state_d;
    logic [cw-1:0]   cnt_q, cnt_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [aw-1:0]   adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic            stb_q, stb_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        stb_d       = stb_q;
        case (state_q)
            IDLE: begin
                if (cmd_ready_q && cmd_valid) begin
                    adr_d       = cmd_adr;
                    dat_d       = cmd_dat;
                    sel_d       = cmd_sel;
                    we_d        = cmd_we;
                    stb_d       = 1'b1;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    state_d     = BUS;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            BUS: begin
                // Ack is checked first so an ack on the final allowed cycle still completes cleanly.
                if (stb_q && i_wb_proc_ack) begin
                    stb_d       = 1'b0;
                    rsp_rdata_d = we_q ? 32'h0 : i_wb_proc_rdt;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == cw'(timeout - 1)) begin
                    stb_d       = 1'b0;
                    rsp_rdata_d = err_data;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + cw'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            adr_q       <= '0;
            dat_q       <= 32'h0;
            sel_q       <= 4'h0;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            stb_q       <= stb_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign o_wb_proc_adr = adr_q;
    assign o_wb_proc_dat = dat_q;
    assign o_wb_proc_sel = sel_q;
    assign o_wb_proc_we  = we_q;
    assign o_wb_proc_stb = stb_q;

endmodule

// File: doc/servgrid_wb_host.md
Name: servgrid_wb_host

Overview:
Wishbone initiator that drives the servgrid external processor port (i_wb_proc_* / o_wb_proc_*) from a simple valid/ready command stream. Used by benches and by a future debug/loader front end to read and write core memories and grid registers. Issues one single-beat classic transfer at a time. Returns read data and an error flag through a held response channel, with a bus timeout.

Parameters:
aw, 32, address width driven on o_wb_proc_adr
timeout, 255, cycles stb may stay high without ack before abort (1..65535)
err_data, 32'hDEADBEEF, rsp_rdata value returned on timeout

Ports:
wb_clk  in  1  system clock, all logic on rising edge
wb_rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_adr  in  aw  byte address
cmd_dat  in  32  write data
cmd_sel  in  4  byte lane select
cmd_we  in  1  1=write, 0=read
rsp_valid  out  1  response present, held until rsp_ready
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  32  read data (0 for writes, err_data on timeout)
rsp_err  out  1  1=transfer timed out
o_wb_proc_adr  out  aw  Wishbone address
o_wb_proc_dat  out  32  Wishbone write data
o_wb_proc_sel  out  4  Wishbone byte select
o_wb_proc_we  out  1  Wishbone write enable
o_wb_proc_stb  out  1  Wishbone strobe (no separate cyc)
i_wb_proc_rdt  in  32  Wishbone read data
i_wb_proc_ack  in  1  Wishbone acknowledge

Behaviour:
- Reset (wb_rst=1 at a clock edge): state=IDLE; cmd_ready=0 during reset cycle, then 1; rsp_valid=0, rsp_err=0, rsp_rdata=0; o_wb_proc_stb=0, we=0, adr=0, dat=0, sel=0; timeout counter=0. Reset mid-transfer drops stb next edge, discards command, no response.
- States: IDLE, BUS, RESP.
- IDLE: cmd_ready=1. On cmd_valid: register adr/dat/sel/we onto o_wb_proc_*, stb=1 next cycle, counter=0, go BUS. Accept-to-stb latency 1 cycle.
- BUS: cmd_ready=0; all o_wb_proc_* held stable. Ack sampled only while stb=1; ack with stb=0 ignored.
  - ack=1: stb=0 next cycle; rsp_rdata = we ? 0 : i_wb_proc_rdt (sampled same edge as ack); rsp_err=0; rsp_valid=1; go RESP. Ack in first stb cycle legal (minimum bus time 1 cycle).
  - ack=0 and counter==timeout-1: stb=0, rsp_rdata=err_data, rsp_err=1, rsp_valid=1, go RESP. stb high exactly timeout cycles.
  - else counter+1 (saturating width = clog2(timeout+1)).
- RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_ready. On rsp_ready: rsp_valid=0 next cycle, go IDLE. cmd_ready=0 in RESP (no overlap; next command accepted earliest 1 cycle after response handshake).
- Ack in same cycle as timeout expiry: ack wins, rsp_err=0.
- o_wb_proc_we/adr/dat/sel keep last values when stb=0 (don't-care to responder, not cleared).
- Throughput: back-to-back zero-wait with rsp_ready tied 1 = 1 transfer per 3 cycles.

Test Plan:
- Write: cmd adr=0x100, dat=0x12345678, sel=0xF, we=1; responder acks 2nd stb cycle -> stb high 2 cycles with stable fields, rsp_valid=1, rsp_rdata=0, rsp_err=0.
- Read zero-wait: adr=0x104, responder acks first stb cycle with rdt=0xCAFEF00D -> stb high 1 cycle, rsp_rdata=0xCAFEF00D, rsp_err=0.
- Timeout: timeout=8, responder never acks -> stb high exactly 8 cycles, rsp_rdata=0xDEADBEEF, rsp_err=1; ack arriving on 8th stb cycle instead -> rsp_err=0 with real data.
- Backpressure: rsp_ready=0 for 5 cycles after response -> rsp fields stable, cmd_ready=0, second cmd_valid not accepted until 1 cycle after rsp handshake.
- Spurious ack: ack pulsed while IDLE and while RESP -> no state change, no extra response.
- Reset mid-transfer: wb_rst=1 on 3rd stb cycle -> stb=0 next edge, rsp_valid stays 0, late ack ignored, next command completes normally.
